// File: rtl/stepgen_array.sv
// stepgen_array: N-channel step/dir generator.
// Each channel runs an NCO accumulator on |cmd| and a pulse FSM. The FSM enforces
// a DIR setup delay on reversal, fixed STP high/low widths and signed position
// feedback. A step request that arrives while one is already pending is dropped
// and flagged in a sticky overrun bit.
module stepgen_array #(
  parameter int CHANNELS    = 5,
  parameter int ACC_WIDTH   = 32,
  parameter int PULSE_WIDTH = 48,
  parameter int DIR_SETUP   = 96
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  error,
  input  logic [CHANNELS-1:0]   joint_enable,
  input  logic [CHANNELS*32-1:0] joint_freq_cmd,
  input  logic                  cmd_strobe,
  output logic [CHANNELS*32-1:0] joint_feedback,
  output logic [CHANNELS-1:0]   STP,
  output logic [CHANNELS-1:0]   DIR,
  output logic [CHANNELS-1:0]   overrun
);

  localparam int CNT_MAX = (PULSE_WIDTH > DIR_SETUP) ? PULSE_WIDTH : DIR_SETUP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HIGH_LOAD  = CW'(PULSE_WIDTH - 1);
  // LOW is one cycle shorter than HIGH: the IDLE cycle that follows completes
  // the minimum low time, so back-to-back steps run at exactly 2*PULSE_WIDTH.
  localparam logic [CW-1:0] LOW_LOAD   = CW'(PULSE_WIDTH - 2);
  localparam logic [CW-1:0] SETUP_LOAD = CW'(DIR_SETUP - 1);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [31:0]          cmd_q;
    logic [31:0]          absv;
    logic [ACC_WIDTH-1:0] mag;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] acc_sum;
    logic                 carry;
    logic                 pending;
    logic                 want_dir;
    logic                 dir_ok;
    logic                 active;
    logic                 consume;
    state_t               state;
    logic [CW-1:0]        cnt;
    logic                 stp_q;
    logic                 dir_q;
    logic                 ovr_q;
    logic [31:0]          fb;

    // Magnitude of the latched command, clamped to the accumulator range.
    always_comb begin
      absv = cmd_q[31] ? (32'd0 - cmd_q) : cmd_q;
      if (absv == 32'h8000_0000) absv = 32'h7FFF_FFFF;
      mag = ((absv >> ACC_WIDTH) != 32'd0) ? '1 : ACC_WIDTH'(absv);
    end

    // Accumulator step, requested direction and the cycle in which the FSM takes the pending request.
    always_comb begin
      {carry, acc_sum} = {1'b0, acc} + {1'b0, mag};
      want_dir = ~cmd_q[31] & (cmd_q != 32'd0);
      dir_ok   = (cmd_q == 32'd0) | (dir_q == want_dir);
      active   = joint_enable[g] & ~error;
      consume  = active & (((state == IDLE) & pending & dir_ok) |
                           ((state == SETUP) & (cnt == '0)));
    end

    // Command latch: all channels load together on the strobe.
    always_ff @(posedge clk) begin
      if (rst)             cmd_q <= '0;
      else if (cmd_strobe) cmd_q <= joint_freq_cmd[32*g +: 32];
    end

    // NCO accumulator, 1-deep pending request and sticky overrun.
    always_ff @(posedge clk) begin
      if (rst) begin
        acc     <= '0;
        pending <= 1'b0;
        ovr_q   <= 1'b0;
      end else if (!active) begin
        acc     <= '0;
        pending <= 1'b0;
      end else begin
        if (cmd_q != 32'd0) acc <= acc_sum;
        if ((cmd_q != 32'd0) && carry) begin
          pending <= 1'b1;
          if (pending && !consume) ovr_q <= 1'b1;
        end else if (consume) begin
          pending <= 1'b0;
        end
      end
    end

    // Pulse FSM: DIR setup on reversal, fixed-width STP high/low, feedback count.
    always_ff @(posedge clk) begin
      if (rst) begin
        state <= IDLE;
        cnt   <= '0;
        stp_q <= 1'b0;
        dir_q <= 1'b0;
        fb    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (active && pending) begin
              if (dir_ok) begin
                state <= HIGH;
                stp_q <= 1'b1;
                cnt   <= HIGH_LOAD;
                fb    <= dir_q ? (fb + 32'd1) : (fb - 32'd1);
              end else begin
                state <= SETUP;
                dir_q <= want_dir;
                cnt   <= SETUP_LOAD;
              end
            end
          end
          SETUP: begin
            if (!active) begin
              state <= IDLE;
            end else if (cnt == '0) begin
              state <= HIGH;
              stp_q <= 1'b1;
              cnt   <= HIGH_LOAD;
              fb    <= dir_q ? (fb + 32'd1) : (fb - 32'd1);
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          HIGH: begin
            if (cnt == '0) begin
              state <= LOW;
              stp_q <= 1'b0;
              cnt   <= LOW_LOAD;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          LOW: begin
            if (cnt == '0) state <= IDLE;
            else           cnt   <= cnt - 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign STP[g]                  = stp_q;
    assign DIR[g]                  = dir_q;
    assign overrun[g]              = ovr_q;
    assign joint_feedback[32*g +: 32] = fb;
  end

endmodule

// File: tb/tb_stepgen_array.sv
// Bench for stepgen_array. The driver predicts every output cycle from an
// event-time reference model and queues it; the monitor compares after each edge.
module tb_stepgen_array;
  localparam int CH = 2;
  localparam int AW = 16;
  localparam int PW = 4;
  localparam int DS = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              error;
  logic [CH-1:0]     joint_enable;
  logic [CH*32-1:0]  joint_freq_cmd;
  logic              cmd_strobe;
  logic [CH*32-1:0]  joint_feedback;
  logic [CH-1:0]     STP;
  logic [CH-1:0]     DIR;
  logic [CH-1:0]     overrun;

  stepgen_array #(.CHANNELS(CH), .ACC_WIDTH(AW), .PULSE_WIDTH(PW), .DIR_SETUP(DS)) dut (
    .clk(clk), .rst(rst), .error(error), .joint_enable(joint_enable),
    .joint_freq_cmd(joint_freq_cmd), .cmd_strobe(cmd_strobe),
    .joint_feedback(joint_feedback), .STP(STP), .DIR(DIR), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at edge %0d: actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  typedef struct {
    int unsigned      k;
    logic [CH-1:0]    stp;
    logic [CH-1:0]    dir;
    logic [CH-1:0]    ovr;
    logic [CH*32-1:0] fb;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: per channel, timestamps of the last rise, of the next edge
  // allowed to start a step, and of a scheduled post-reversal rise.
  longint      m_acc[CH];
  bit          m_pend[CH];
  bit          m_dir[CH];
  bit          m_ovr[CH];
  logic [31:0] m_cmd[CH];
  logic [31:0] m_fb[CH];
  int          m_setup[CH];
  int          m_free[CH];
  int          m_rise[CH];

  function automatic longint mag_of(input logic [31:0] c);
    longint v;
    v = longint'($signed(c));
    if (v < 0) v = -v;
    if (v > 64'sh7FFF_FFFF) v = 64'sh7FFF_FFFF;
    if (v > (longint'(1) << AW) - 1) v = (longint'(1) << AW) - 1;
    return v;
  endfunction

  task automatic fire(input int c, input int k);
    m_fb[c]   = m_dir[c] ? (m_fb[c] + 32'd1) : (m_fb[c] - 32'd1);
    m_rise[c] = k;
    m_free[c] = k + 2 * PW;
  endtask

  task automatic model_edge(input int k);
    exp_t e;
    for (int c = 0; c < CH; c++) begin
      if (rst) begin
        m_cmd[c] = '0; m_acc[c] = 0; m_pend[c] = 0; m_dir[c] = 0; m_ovr[c] = 0;
        m_fb[c] = '0; m_setup[c] = -1; m_free[c] = 0; m_rise[c] = -100;
      end else begin
        bit act, cons, want, carry;
        longint sum;
        act  = joint_enable[c] && !error;
        want = ($signed(m_cmd[c]) > 0);
        cons = 0;
        if (m_setup[c] >= 0) begin
          if (!act) m_setup[c] = -1;
          else if (k == m_setup[c]) begin fire(c, k); cons = 1; m_setup[c] = -1; end
        end else if (k >= m_free[c] && m_pend[c] && act) begin
          if (m_cmd[c] == 0 || want == m_dir[c]) begin fire(c, k); cons = 1; end
          else begin m_dir[c] = want; m_setup[c] = k + DS; end
        end
        if (!act) begin
          m_acc[c] = 0; m_pend[c] = 0;
        end else if (m_cmd[c] != 0) begin
          sum      = m_acc[c] + mag_of(m_cmd[c]);
          carry    = (sum >= (longint'(1) << AW));
          m_acc[c] = sum % (longint'(1) << AW);
          if (carry) begin
            if (m_pend[c] && !cons) m_ovr[c] = 1;
            m_pend[c] = 1;
          end else if (cons) m_pend[c] = 0;
        end else if (cons) m_pend[c] = 0;
        if (cmd_strobe) m_cmd[c] = joint_freq_cmd[32*c +: 32];
      end
      e.stp[c] = (k >= m_rise[c]) && (k < m_rise[c] + PW);
      e.dir[c] = m_dir[c];
      e.ovr[c] = m_ovr[c];
      e.fb[32*c +: 32] = m_fb[c];
    end
    e.k = k;
    exp_q.push_back(e);
  endtask

  // Predict the coming edge from the inputs now applied, then move to the next negedge.
  task automatic step_cycle();
    model_edge(int'(cyc) + 1);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_cmd();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'd0;
      1: v = 32'h8000_0000;
      2: v = 32'h7FFF_FFFF;
      3: v = $urandom;
      default: begin
        v = 32'($urandom_range(1, 32'h3000));
        if ($urandom_range(0, 1) == 1) v = 32'd0 - v;
      end
    endcase
    return v;
  endfunction

  // Monitor: one queued expectation per edge, compared 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("edge_sync", 64'(cyc), 64'(e.k));
        chk("stp", 64'(STP), 64'(e.stp));
        chk("dir", 64'(DIR), 64'(e.dir));
        chk("overrun", 64'(overrun), 64'(e.ovr));
        chk("feedback", 64'(joint_feedback), 64'(e.fb));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  task automatic do_reset(input int n);
    rst = 1'b1; cmd_strobe = 1'b0; error = 1'b0; joint_enable = '0;
    repeat (n) step_cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] fb_hold;
    int hi;

    rst = 1'b1; error = 1'b0; joint_enable = '0; joint_freq_cmd = '0; cmd_strobe = 1'b0;

    // Reset with random inputs present
    for (int i = 0; i < 3; i++) begin
      error = 1'($urandom); joint_enable = CH'($urandom);
      joint_freq_cmd = {$urandom, $urandom}; cmd_strobe = 1'($urandom);
      step_cycle();
      chk("rst_stp", 64'(STP), 64'd0);
      chk("rst_fb", 64'(joint_feedback), 64'd0);
    end
    rst = 1'b0; error = 1'b0; joint_enable = '0; cmd_strobe = 1'b0;
    step_cycle();
    chk("post_rst_dir", 64'(DIR), 64'd0);
    chk("post_rst_ovr", 64'(overrun), 64'd0);

    // Steady run on channel 0, channel 1 disabled
    joint_freq_cmd = {32'h0000_1234, 32'h0000_1000};
    joint_enable = 2'b01; cmd_strobe = 1'b1;
    step_cycle();
    cmd_strobe = 1'b0;
    repeat (165) step_cycle();
    chk("run_fb0", 64'(joint_feedback[31:0]), 64'd10);
    chk("run_dir0", 64'(DIR[0]), 64'd1);
    chk("run_fb1", 64'(joint_feedback[63:32]), 64'd0);

    // Reversal
    joint_freq_cmd[31:0] = 32'hFFFF_F000; cmd_strobe = 1'b1;
    step_cycle();
    cmd_strobe = 1'b0;
    repeat (200) step_cycle();
    chk("rev_dir0", 64'(DIR[0]), 64'd0);

    // Error raised during the second high cycle of a pulse
    do_reset(2);
    joint_freq_cmd[31:0] = 32'h0000_1000; joint_enable = 2'b01; cmd_strobe = 1'b1;
    step_cycle();
    cmd_strobe = 1'b0;
    for (int i = 0; i < 100 && !STP[0]; i++) step_cycle();
    chk("err_first_rise", 64'(STP[0]), 64'd1);
    step_cycle();
    hi = 2;
    error = 1'b1;
    fb_hold = joint_feedback[31:0];
    for (int i = 0; i < 60; i++) begin
      step_cycle();
      if (STP[0]) hi++;
    end
    chk("err_high_len", 64'(hi), 64'(PW));
    chk("err_fb_hold", 64'(joint_feedback[31:0]), 64'(fb_hold));
    error = 1'b0;
    repeat (40) step_cycle();

    // Overrun at a step rate above the minimum period
    do_reset(2);
    joint_freq_cmd = {32'h0000_0100, 32'h0000_C000}; joint_enable = 2'b11; cmd_strobe = 1'b1;
    step_cycle();
    cmd_strobe = 1'b0;
    repeat (60) step_cycle();
    chk("ovr0_set", 64'(overrun[0]), 64'd1);
    chk("ovr1_clear", 64'(overrun[1]), 64'd0);
    joint_enable = 2'b00;
    repeat (20) step_cycle();
    chk("ovr0_sticky", 64'(overrun[0]), 64'd1);

    // Most-negative command and feedback wrap below zero
    do_reset(2);
    joint_freq_cmd = {32'h8000_0000, 32'h0}; joint_enable = 2'b10; cmd_strobe = 1'b1;
    step_cycle();
    cmd_strobe = 1'b0;
    repeat (6) step_cycle();
    chk("sat_dir1", 64'(DIR[1]), 64'd0);
    chk("wrap_fb1", 64'(joint_feedback[63:32]), 64'hFFFF_FFFF);
    repeat (30) step_cycle();

    // Randomised traffic
    joint_enable = 2'b11;
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      cmd_strobe = ($urandom_range(0, 19) == 0);
      if (cmd_strobe)
        for (int c = 0; c < CH; c++) joint_freq_cmd[32*c +: 32] = rand_cmd();
      if ($urandom_range(0, 29) == 0) joint_enable = CH'($urandom);
      if (error) error = ($urandom_range(0, 7) != 0);
      else       error = ($urandom_range(0, 59) == 0);
      step_cycle();
    end
    rst = 1'b0; cmd_strobe = 1'b0;
    step_cycle();
    @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
